// File: rtl/adma_pkg.sv
// ADMA descriptor engine: shared states, codes and descriptor layout.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FDS  = 2'd1,
    ST_CADR = 2'd2,
    ST_TFR  = 2'd3
  } state_t;

  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSV  = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  localparam logic [63:0] DESC_STRIDE = 64'd16;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_FDS  = 2'd1;
  localparam logic [1:0] ERR_CADR = 2'd2;
  localparam logic [1:0] ERR_TFR  = 2'd3;

  localparam int LEN_HI    = 31;
  localparam int LEN_LO    = 16;
  localparam int ACT_HI    = 5;
  localparam int ACT_LO    = 4;
  localparam int INT_BIT   = 2;
  localparam int END_BIT   = 1;
  localparam int VALID_BIT = 0;

  function automatic logic [1:0] err_of(state_t s);
    unique case (s)
      ST_FDS:  return ERR_FDS;
      ST_CADR: return ERR_CADR;
      ST_TFR:  return ERR_TFR;
      default: return ERR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/adma_desc_reg.sv
// Holds the three fetched descriptor words and exposes decoded fields.
import adma_pkg::*;

module adma_desc_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [1:0]  sel,
  input  logic [31:0] word,
  output logic        valid,
  output logic        last,
  output logic        irq,
  output logic [1:0]  act,
  output logic [15:0] len,
  output logic [63:0] addr
);

  logic [31:0] w0;
  logic [31:0] w1;
  logic [31:0] w2;

  always_ff @(posedge clk) begin
    if (reset) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else if (load) begin
      unique case (sel)
        2'd0:    w0 <= word;
        2'd1:    w1 <= word;
        default: w2 <= word;
      endcase
    end
  end

  assign valid = w0[VALID_BIT];
  assign last  = w0[END_BIT];
  assign irq   = w0[INT_BIT];
  assign act   = w0[ACT_HI:ACT_LO];
  assign len   = w0[LEN_HI:LEN_LO];
  assign addr  = {w2, w1};

  // reserved attribute bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{w0[15:6], w0[3]};

endmodule

// File: rtl/adma_fsm.sv
// ADMA descriptor walker: fetches 128-bit descriptors and
// hands TRAN entries to the transfer stage.
import adma_pkg::*;

module adma_fsm (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        adma_start,
  input  logic        adma_abort,
  input  logic [63:0] adma_sys_addr,
  input  logic        dir_mode,
  output logic        ram_read,
  output logic [63:0] ram_address,
  input  logic [31:0] data_from_ram,
  output logic        start,
  output logic        direction,
  output logic [63:0] address_init,
  output logic [15:0] length,
  input  logic        TFC,
  output logic        adma_error,
  output logic [1:0]  error_state,
  output logic        int_pulse,
  output logic        xfer_done,
  output logic [1:0]  state
);

  state_t      st;
  logic [1:0]  fcnt;
  logic        first;
  logic [63:0] desc_ptr;
  logic [63:0] ptr_next;

  logic        d_valid;
  logic        d_last;
  logic        d_irq;
  logic [1:0]  d_act;
  logic [15:0] d_len;
  logic [63:0] d_addr;
  logic        tran_go;
  logic        is_nop;

  assign ptr_next = desc_ptr + DESC_STRIDE;
  assign tran_go  = (d_act == ACT_TRAN) && (d_len != 16'd0);
  assign is_nop   = (d_act == ACT_NOP) || (d_act == ACT_RSV);
  assign state    = st;

  // word k arrives while fcnt == k+1
  adma_desc_reg u_desc (
    .clk   (CLK),
    .reset (RESET),
    .load  ((st == ST_FDS) && (fcnt != 2'd0)),
    .sel   (fcnt - 2'd1),
    .word  (data_from_ram),
    .valid (d_valid),
    .last  (d_last),
    .irq   (d_irq),
    .act   (d_act),
    .len   (d_len),
    .addr  (d_addr)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st           <= ST_STOP;
      fcnt         <= 2'd0;
      first        <= 1'b0;
      desc_ptr     <= '0;
      ram_read     <= 1'b0;
      ram_address  <= '0;
      start        <= 1'b0;
      direction    <= 1'b0;
      address_init <= '0;
      length       <= '0;
      adma_error   <= 1'b0;
      error_state  <= ERR_NONE;
      int_pulse    <= 1'b0;
      xfer_done    <= 1'b0;
    end else begin
      int_pulse <= 1'b0;
      xfer_done <= 1'b0;
      if (adma_abort && st != ST_STOP) begin
        st          <= ST_STOP;
        start       <= 1'b0;
        ram_read    <= 1'b0;
        adma_error  <= 1'b1;
        error_state <= err_of(st);
      end else begin
        unique case (st)
          ST_STOP: begin
            if (adma_start) begin
              desc_ptr    <= adma_sys_addr;
              adma_error  <= 1'b0;
              error_state <= ERR_NONE;
              st          <= ST_FDS;
              fcnt        <= 2'd0;
              ram_read    <= 1'b1;
              ram_address <= adma_sys_addr;
            end
          end
          ST_FDS: begin
            fcnt <= fcnt + 2'd1;
            unique case (fcnt)
              2'd0:    ram_address <= desc_ptr + 64'd4;
              2'd1:    ram_address <= desc_ptr + 64'd8;
              2'd2:    ram_read <= 1'b0;
              default: st <= ST_CADR;
            endcase
          end
          ST_CADR: begin
            unique case (1'b1)
              !d_valid: begin
                st          <= ST_STOP;
                adma_error  <= 1'b1;
                error_state <= ERR_FDS;
              end
              d_valid && d_act == ACT_LINK: begin
                desc_ptr <= d_addr;
                if (d_last) begin
                  st        <= ST_STOP;
                  xfer_done <= 1'b1;
                end else begin
                  st          <= ST_FDS;
                  fcnt        <= 2'd0;
                  ram_read    <= 1'b1;
                  ram_address <= d_addr;
                end
              end
              d_valid && tran_go: begin
                address_init <= d_addr;
                length       <= d_len;
                direction    <= dir_mode;
                start        <= 1'b1;
                first        <= 1'b1;
                st           <= ST_TFR;
              end
              default: begin
                desc_ptr  <= ptr_next;
                int_pulse <= is_nop && d_irq;
                if (d_last) begin
                  st        <= ST_STOP;
                  xfer_done <= 1'b1;
                end else begin
                  st          <= ST_FDS;
                  fcnt        <= 2'd0;
                  ram_read    <= 1'b1;
                  ram_address <= ptr_next;
                end
              end
            endcase
          end
          ST_TFR: begin
            // idle transfer stage reports TFC high, so skip the first cycle
            if (first) begin
              first <= 1'b0;
            end else if (TFC) begin
              start     <= 1'b0;
              desc_ptr  <= ptr_next;
              int_pulse <= d_irq;
              if (d_last) begin
                st        <= ST_STOP;
                xfer_done <= 1'b1;
              end else begin
                st          <= ST_FDS;
                fcnt        <= 2'd0;
                ram_read    <= 1'b1;
                ram_address <= ptr_next;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adma_fsm.sv
// Scoreboard bench for adma_fsm: directed descriptor tables,
// expected bus events queued up front and checked by a monitor.
module tb_adma_fsm;

  localparam int K_RD = 0;
  localparam int K_ST = 1;
  localparam int K_INT = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR = 4;

  logic        CLK;
  logic        RESET;
  logic        adma_start;
  logic        adma_abort;
  logic [63:0] adma_sys_addr;
  logic        dir_mode;
  logic        ram_read;
  logic [63:0] ram_address;
  logic [31:0] data_from_ram;
  logic        start;
  logic        direction;
  logic [63:0] address_init;
  logic [15:0] length;
  logic        TFC;
  logic        adma_error;
  logic [1:0]  error_state;
  logic        int_pulse;
  logic        xfer_done;
  logic [1:0]  state;

  adma_fsm dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .adma_start    (adma_start),
    .adma_abort    (adma_abort),
    .adma_sys_addr (adma_sys_addr),
    .dir_mode      (dir_mode),
    .ram_read      (ram_read),
    .ram_address   (ram_address),
    .data_from_ram (data_from_ram),
    .start         (start),
    .direction     (direction),
    .address_init  (address_init),
    .length        (length),
    .TFC           (TFC),
    .adma_error    (adma_error),
    .error_state   (error_state),
    .int_pulse     (int_pulse),
    .xfer_done     (xfer_done),
    .state         (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [63:0] v;
    logic [16:0] v2;
    int          cyc;
  } ev_t;

  ev_t   exp_q[$];
  int    n_pass = 0;
  int    n_tot = 0;
  int    cyc = 0;
  int    t0 = 0;
  string tname = "reset";
  logic  start_q = 1'b0;
  logic  err_q = 1'b0;

  logic [31:0] mem [logic [63:0]];

  function automatic logic [31:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge CLK) begin
    if (ram_read) data_from_ram <= rd(ram_address);
  end

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (adma_start) t0 = cyc;
  end

  task automatic push(input int k, input logic [63:0] v,
                      input logic [16:0] v2, input int c);
    ev_t e;
    e.kind = k;
    e.v = v;
    e.v2 = v2;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [63:0] v,
                          input logic [16:0] v2);
    ev_t e;
    int  rel;
    rel = cyc - t0 + 1;
    n_tot++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s unexpected: got kind=%0d val=%h/%h cyc=%0d, want none",
               tname, k, v, v2, rel);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.v == v && e.v2 == v2 &&
          (e.cyc < 0 || e.cyc == rel))
        n_pass++;
      else
        $display("FAIL %s event: got kind=%0d val=%h/%h cyc=%0d, want kind=%0d val=%h/%h cyc=%0d",
                 tname, k, v, v2, rel, e.kind, e.v, e.v2, e.cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (int_pulse) check_ev(K_INT, 64'd0, 17'd0);
    if (xfer_done) check_ev(K_DONE, 64'd0, 17'd0);
    if (adma_error && !err_q) check_ev(K_ERR, {62'd0, error_state}, 17'd0);
    if (start && !start_q) check_ev(K_ST, address_init, {direction, length});
    if (ram_read) check_ev(K_RD, ram_address, 17'd0);
    start_q = start;
    err_q = adma_error;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %h, want %h", tname, name, act, exp);
  endtask

  task automatic put_desc(input logic [63:0] a, input logic [15:0] len,
                          input logic [1:0] act, input logic irq,
                          input logic last, input logic valid,
                          input logic [63:0] target);
    mem[a]      = {len, 10'd0, act, 1'b0, irq, last, valid};
    mem[a + 4]  = target[31:0];
    mem[a + 8]  = target[63:32];
    mem[a + 12] = 32'hdead_beef;
  endtask

  task automatic go(input logic [63:0] base);
    @(negedge CLK);
    adma_sys_addr = base;
    adma_start = 1'b1;
    @(negedge CLK);
    adma_start = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 40; i++) begin
      if (start) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) begin
      n_tot++;
      $display("FAIL %s start_timeout: got start=0, want start=1", tname);
    end
  endtask

  // transfer stage: TFC stays high through the first TFR cycle,
  // drops, then returns after busy more cycles
  task automatic xfer(input int busy);
    bit ok;
    wait_start(ok);
    if (ok) begin
      @(negedge CLK);
      TFC = 1'b0;
      repeat (busy) @(negedge CLK);
      TFC = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    RESET = 1'b1;
    adma_start = 1'b0;
    adma_abort = 1'b0;
    adma_sys_addr = '0;
    dir_mode = 1'b0;
    TFC = 1'b1;
    data_from_ram = '0;

    repeat (3) @(negedge CLK);
    chk("reset_outs", {63'd0, |{ram_read, ram_address, start, direction,
        address_init, length, adma_error, error_state, int_pulse,
        xfer_done}}, 64'd0);
    chk("reset_state", {62'd0, state}, 64'd0);
    RESET = 1'b0;

    tname = "tran_single";
    mem.delete();
    put_desc(64'h1000, 16'h0040, 2'b10, 1'b0, 1'b1, 1'b1, 64'h8000);
    dir_mode = 1'b1;
    push(K_RD, 64'h1000, 17'd0, 1);
    push(K_RD, 64'h1004, 17'd0, 2);
    push(K_RD, 64'h1008, 17'd0, 3);
    push(K_ST, 64'h8000, {1'b1, 16'h0040}, 6);
    push(K_DONE, 64'd0, 17'd0, 10);
    go(64'h1000);
    xfer(2);
    repeat (3) @(negedge CLK);
    chk("state", {62'd0, state}, 64'd0);
    chk("start", {63'd0, start}, 64'd0);
    chk("queue", exp_q.size(), 64'd0);
    adma_abort = 1'b1;
    @(negedge CLK);
    adma_abort = 1'b0;
    @(negedge CLK);
    chk("idle_abort_err", {63'd0, adma_error}, 64'd0);
    chk("idle_abort_state", {62'd0, state}, 64'd0);

    tname = "link";
    mem.delete();
    put_desc(64'h1000, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 64'h2000);
    put_desc(64'h2000, 16'h0010, 2'b10, 1'b0, 1'b1, 1'b1,
             64'h0000_0001_0000_4000);
    dir_mode = 1'b0;
    push(K_RD, 64'h1000, 17'd0, 1);
    push(K_RD, 64'h1004, 17'd0, 2);
    push(K_RD, 64'h1008, 17'd0, 3);
    push(K_RD, 64'h2000, 17'd0, 6);
    push(K_RD, 64'h2004, 17'd0, 7);
    push(K_RD, 64'h2008, 17'd0, 8);
    push(K_ST, 64'h0000_0001_0000_4000, {1'b0, 16'h0010}, 11);
    push(K_DONE, 64'd0, 17'd0, 14);
    go(64'h1000);
    xfer(1);
    repeat (3) @(negedge CLK);
    chk("queue", exp_q.size(), 64'd0);

    tname = "invalid";
    mem.delete();
    put_desc(64'h3000, 16'h0040, 2'b10, 1'b0, 1'b1, 1'b0, 64'h8000);
    push(K_RD, 64'h3000, 17'd0, 1);
    push(K_RD, 64'h3004, 17'd0, 2);
    push(K_RD, 64'h3008, 17'd0, 3);
    push(K_ERR, 64'd1, 17'd0, 6);
    go(64'h3000);
    repeat (8) @(negedge CLK);
    chk("adma_error", {63'd0, adma_error}, 64'd1);
    chk("error_state", {62'd0, error_state}, 64'd1);
    chk("state", {62'd0, state}, 64'd0);
    chk("queue", exp_q.size(), 64'd0);

    tname = "two_tran";
    mem.delete();
    put_desc(64'h4000, 16'h0020, 2'b10, 1'b1, 1'b0, 1'b1, 64'hA000);
    put_desc(64'h4010, 16'h0030, 2'b10, 1'b0, 1'b1, 1'b1, 64'hB000);
    dir_mode = 1'b1;
    push(K_RD, 64'h4000, 17'd0, 1);
    push(K_RD, 64'h4004, 17'd0, 2);
    push(K_RD, 64'h4008, 17'd0, 3);
    push(K_ST, 64'hA000, {1'b1, 16'h0020}, 6);
    push(K_INT, 64'd0, 17'd0, 9);
    push(K_RD, 64'h4010, 17'd0, 9);
    push(K_RD, 64'h4014, 17'd0, 10);
    push(K_RD, 64'h4018, 17'd0, 11);
    push(K_ST, 64'hB000, {1'b1, 16'h0030}, 14);
    push(K_DONE, 64'd0, 17'd0, 17);
    go(64'h4000);
    xfer(1);
    xfer(1);
    repeat (3) @(negedge CLK);
    chk("adma_error", {63'd0, adma_error}, 64'd0);
    chk("queue", exp_q.size(), 64'd0);

    tname = "abort_tfc";
    mem.delete();
    put_desc(64'h5000, 16'h0008, 2'b10, 1'b1, 1'b1, 1'b1, 64'hC000);
    push(K_RD, 64'h5000, 17'd0, 1);
    push(K_RD, 64'h5004, 17'd0, 2);
    push(K_RD, 64'h5008, 17'd0, 3);
    push(K_ST, 64'hC000, {1'b1, 16'h0008}, 6);
    push(K_ERR, 64'd3, 17'd0, 9);
    go(64'h5000);
    wait_start(ok);
    @(negedge CLK);
    TFC = 1'b0;
    @(negedge CLK);
    TFC = 1'b1;
    adma_abort = 1'b1;
    @(negedge CLK);
    adma_abort = 1'b0;
    chk("state", {62'd0, state}, 64'd0);
    chk("start", {63'd0, start}, 64'd0);
    chk("ram_read", {63'd0, ram_read}, 64'd0);
    chk("error_state", {62'd0, error_state}, 64'd3);
    repeat (3) @(negedge CLK);
    chk("adma_error", {63'd0, adma_error}, 64'd1);
    chk("queue", exp_q.size(), 64'd0);

    tname = "reset_fetch";
    mem.delete();
    put_desc(64'h6000, 16'h0004, 2'b10, 1'b0, 1'b1, 1'b1, 64'hD000);
    push(K_RD, 64'h6000, 17'd0, 1);
    push(K_RD, 64'h6004, 17'd0, 2);
    go(64'h6000);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("outs_zero", {63'd0, |{ram_read, ram_address, start, direction,
        address_init, length, adma_error, error_state, int_pulse,
        xfer_done}}, 64'd0);
    chk("state", {62'd0, state}, 64'd0);
    RESET = 1'b0;
    chk("queue", exp_q.size(), 64'd0);
    tname = "restart";
    push(K_RD, 64'h6000, 17'd0, 1);
    push(K_RD, 64'h6004, 17'd0, 2);
    push(K_RD, 64'h6008, 17'd0, 3);
    push(K_ST, 64'hD000, {1'b1, 16'h0004}, 6);
    push(K_DONE, 64'd0, 17'd0, 9);
    go(64'h6000);
    xfer(1);
    repeat (3) @(negedge CLK);
    chk("state", {62'd0, state}, 64'd0);
    chk("queue", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
